// File: rtl/dcmac_0_axis_pkt_mon_seg_check.sv
// RX segmented-bus packet monitor: tracks per-port packet state across the
// 12 x 128-bit segments, measures packet lengths and keeps per-port
// packet/byte/error/runt/oversize counters plus sticky protocol flags.
module dcmac_0_axis_pkt_mon_seg_check #(
  parameter int NUM_ID  = 6,
  parameter int ID_W    = (NUM_ID == 1) ? 1 : $clog2(NUM_ID),
  parameter int MIN_LEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] i_id,
  input  logic [11:0]     i_ena,
  input  logic [11:0]     i_sop,
  input  logic [11:0]     i_eop,
  input  logic [11:0]     i_err,
  input  logic [47:0]     i_mty,
  input  logic [15:0]     i_max_len,
  input  logic            i_clear,
  input  logic [ID_W-1:0] i_stat_id,
  output logic [31:0]     o_pkt_cnt,
  output logic [47:0]     o_byte_cnt,
  output logic [31:0]     o_bad_cnt,
  output logic [31:0]     o_runt_cnt,
  output logic [31:0]     o_over_cnt,
  output logic [4:0]      o_viol
);

  // Stage 1 input registers
  logic [ID_W-1:0] id_q;
  logic [11:0]     ena_q, sop_q, eop_q, err_q;
  logic [47:0]     mty_q;
  logic [15:0]     max_len_q;

  // Per-port state and statistics
  logic            in_pkt_q   [NUM_ID];
  logic [15:0]     run_len_q  [NUM_ID];
  logic [31:0]     pkt_cnt_q  [NUM_ID];
  logic [47:0]     byte_cnt_q [NUM_ID];
  logic [31:0]     bad_cnt_q  [NUM_ID];
  logic [31:0]     runt_cnt_q [NUM_ID];
  logic [31:0]     over_cnt_q [NUM_ID];
  logic [4:0]      viol_q;

  // Stage 2 combinational results for the port owning the registered cycle
  logic            id_ok;
  logic [ID_W-1:0] idx;
  logic            in_d;
  logic [15:0]     len_d;
  logic [3:0]      pkt_inc, bad_inc, runt_inc, over_inc;
  logic [19:0]     byte_inc;
  logic [4:0]      viol_set;
  logic [3:0]      seg_mty;
  logic [4:0]      seg_bytes;
  logic [16:0]     len_sum;
  logic            seg_live;

  logic            stat_ok;
  logic [ID_W-1:0] sidx;

  // Stage 1: capture the bus cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      ena_q     <= '0;
      sop_q     <= '0;
      eop_q     <= '0;
      err_q     <= '0;
      mty_q     <= '0;
      max_len_q <= '0;
    end else begin
      id_q      <= i_id;
      ena_q     <= i_ena;
      sop_q     <= i_sop;
      eop_q     <= i_eop;
      err_q     <= i_err;
      mty_q     <= i_mty;
      max_len_q <= i_max_len;
    end
  end

  // Stage 2: walk segments 0..11 in order, carrying in-packet state through the cycle
  always_comb begin
    id_ok     = 32'(id_q) < 32'(NUM_ID);
    idx       = id_ok ? id_q : '0;
    in_d      = in_pkt_q[idx];
    len_d     = run_len_q[idx];
    pkt_inc   = '0;
    bad_inc   = '0;
    runt_inc  = '0;
    over_inc  = '0;
    byte_inc  = '0;
    viol_set  = '0;
    seg_mty   = '0;
    seg_bytes = '0;
    len_sum   = '0;
    seg_live  = 1'b0;
    for (int unsigned s = 0; s < 12; s++) begin
      if (ena_q[s]) begin
        seg_mty = mty_q[s*4 +: 4];
        if (!eop_q[s] && seg_mty != 4'd0) begin
          viol_set[3] = 1'b1;
          seg_mty     = '0;
        end
        seg_bytes = eop_q[s] ? (5'd16 - {1'b0, seg_mty}) : 5'd16;
        seg_live  = 1'b1;
        if (sop_q[s]) begin
          if (in_d) viol_set[0] = 1'b1;
          in_d  = 1'b1;
          len_d = {11'd0, seg_bytes};
        end else if (in_d) begin
          len_sum = {1'b0, len_d} + {12'd0, seg_bytes};
          len_d   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        end else begin
          viol_set[2] = 1'b1;
          if (eop_q[s]) viol_set[1] = 1'b1;
          seg_live = 1'b0;
        end
        if (seg_live && eop_q[s]) begin
          pkt_inc  = pkt_inc + 4'd1;
          byte_inc = byte_inc + {4'd0, len_d};
          if (err_q[s]) bad_inc = bad_inc + 4'd1;
          if (len_d < 16'(MIN_LEN)) runt_inc = runt_inc + 4'd1;
          if (len_d > max_len_q) over_inc = over_inc + 4'd1;
          in_d = 1'b0;
        end
      end
    end
    // An out-of-range id discards the whole cycle except for its own flag
    if (!id_ok) begin
      viol_set = 5'b10000;
      pkt_inc  = '0;
      bad_inc  = '0;
      runt_inc = '0;
      over_inc = '0;
      byte_inc = '0;
    end
  end

  // Stage 2: commit port state and counters; clear wipes stats but keeps packet tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_ID; p++) begin
        in_pkt_q[p]   <= 1'b0;
        run_len_q[p]  <= '0;
        pkt_cnt_q[p]  <= '0;
        byte_cnt_q[p] <= '0;
        bad_cnt_q[p]  <= '0;
        runt_cnt_q[p] <= '0;
        over_cnt_q[p] <= '0;
      end
      viol_q <= '0;
    end else begin
      if (id_ok) begin
        in_pkt_q[idx]  <= in_d;
        run_len_q[idx] <= len_d;
      end
      if (i_clear) begin
        for (int unsigned p = 0; p < NUM_ID; p++) begin
          pkt_cnt_q[p]  <= '0;
          byte_cnt_q[p] <= '0;
          bad_cnt_q[p]  <= '0;
          runt_cnt_q[p] <= '0;
          over_cnt_q[p] <= '0;
        end
        viol_q <= '0;
      end else begin
        if (id_ok) begin
          pkt_cnt_q[idx]  <= pkt_cnt_q[idx]  + 32'(pkt_inc);
          byte_cnt_q[idx] <= byte_cnt_q[idx] + 48'(byte_inc);
          bad_cnt_q[idx]  <= bad_cnt_q[idx]  + 32'(bad_inc);
          runt_cnt_q[idx] <= runt_cnt_q[idx] + 32'(runt_inc);
          over_cnt_q[idx] <= over_cnt_q[idx] + 32'(over_inc);
        end
        viol_q <= viol_q | viol_set;
      end
    end
  end

  assign stat_ok = 32'(i_stat_id) < 32'(NUM_ID);
  assign sidx    = stat_ok ? i_stat_id : '0;

  // Stage 3: registered stats readback mux
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pkt_cnt  <= '0;
      o_byte_cnt <= '0;
      o_bad_cnt  <= '0;
      o_runt_cnt <= '0;
      o_over_cnt <= '0;
      o_viol     <= '0;
    end else begin
      o_pkt_cnt  <= stat_ok ? pkt_cnt_q[sidx]  : '0;
      o_byte_cnt <= stat_ok ? byte_cnt_q[sidx] : '0;
      o_bad_cnt  <= stat_ok ? bad_cnt_q[sidx]  : '0;
      o_runt_cnt <= stat_ok ? runt_cnt_q[sidx] : '0;
      o_over_cnt <= stat_ok ? over_cnt_q[sidx] : '0;
      o_viol     <= viol_q;
    end
  end

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_seg_check.sv
// Self-checking bench for the RX segment monitor: directed scenarios plus
// randomized back-to-back traffic against a packet-level reference model.
module tb_dcmac_0_axis_pkt_mon_seg_check;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  i_id;
  logic [11:0] i_ena, i_sop, i_eop, i_err;
  logic [47:0] i_mty;
  logic [15:0] i_max_len;
  logic        i_clear;
  logic [2:0]  i_stat_id;
  logic [31:0] o_pkt_cnt, o_bad_cnt, o_runt_cnt, o_over_cnt;
  logic [47:0] o_byte_cnt;
  logic [4:0]  o_viol;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit              m_in   [8];
  int unsigned     m_len  [8];
  int unsigned     m_pkt  [8];
  int unsigned     m_bad  [8];
  int unsigned     m_runt [8];
  int unsigned     m_over [8];
  longint unsigned m_byte [8];
  bit [4:0]        m_viol;

  // Readback values
  logic [31:0] r_pkt, r_bad, r_runt, r_over;
  logic [47:0] r_byte;
  logic [4:0]  r_viol;

  dcmac_0_axis_pkt_mon_seg_check #(.NUM_ID(6), .MIN_LEN(64)) dut (
    .clk(clk), .rst(rst), .i_id(i_id), .i_ena(i_ena), .i_sop(i_sop),
    .i_eop(i_eop), .i_err(i_err), .i_mty(i_mty), .i_max_len(i_max_len),
    .i_clear(i_clear), .i_stat_id(i_stat_id), .o_pkt_cnt(o_pkt_cnt),
    .o_byte_cnt(o_byte_cnt), .o_bad_cnt(o_bad_cnt), .o_runt_cnt(o_runt_cnt),
    .o_over_cnt(o_over_cnt), .o_viol(o_viol)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int p = 0; p < 8; p++) begin
      m_pkt[p] = 0; m_bad[p] = 0; m_runt[p] = 0; m_over[p] = 0; m_byte[p] = 0;
    end
    m_viol = '0;
  endfunction

  // Packet-level model: each enabled segment contributes 16 bytes (16-mty on eop)
  function automatic void model_apply(input int id, input logic [11:0] ena, sop, eop, err,
                                      input logic [47:0] mty, input int maxlen);
    int unsigned b;
    int unsigned m;
    if (id >= 6) begin
      m_viol[4] = 1'b1;
      return;
    end
    for (int s = 0; s < 12; s++) begin
      if (!ena[s]) continue;
      m = 32'(mty[s*4 +: 4]);
      if (!eop[s] && m != 0) begin m_viol[3] = 1'b1; m = 0; end
      b = eop[s] ? 16 - m : 16;
      if (sop[s]) begin
        if (m_in[id]) m_viol[0] = 1'b1;
        m_in[id] = 1'b1;
        m_len[id] = b;
      end else if (m_in[id]) begin
        m_len[id] = (m_len[id] + b > 65535) ? 65535 : m_len[id] + b;
      end else begin
        m_viol[2] = 1'b1;
        if (eop[s]) m_viol[1] = 1'b1;
        continue;
      end
      if (eop[s]) begin
        m_pkt[id]++;
        m_byte[id] = (m_byte[id] + m_len[id]) & 48'hFFFF_FFFF_FFFF;
        if (err[s]) m_bad[id]++;
        if (m_len[id] < 64) m_runt[id]++;
        if (m_len[id] > maxlen) m_over[id]++;
        m_in[id] = 1'b0;
      end
    end
  endfunction

  task automatic idle_inputs();
    i_id = '0; i_ena = '0; i_sop = '0; i_eop = '0; i_err = '0; i_mty = '0;
  endtask

  // One bus cycle; optionally assert i_clear on the edge where this cycle commits
  task automatic drive_beat(input logic [2:0] id, input logic [11:0] ena, sop, eop, err,
                            input logic [47:0] mty, input bit clr);
    i_id = id; i_ena = ena; i_sop = sop; i_eop = eop; i_err = err; i_mty = mty;
    @(posedge clk); #1;
    idle_inputs();
    model_apply(int'(id), ena, sop, eop, err, mty, int'(i_max_len));
    if (clr) begin
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      model_clear();
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    model_clear();
  endtask

  task automatic read_port(input int p);
    i_stat_id = 3'(p);
    repeat (3) @(posedge clk);
    #1;
    r_pkt = o_pkt_cnt; r_byte = o_byte_cnt; r_bad = o_bad_cnt;
    r_runt = o_runt_cnt; r_over = o_over_cnt; r_viol = o_viol;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_clear = 1'b0; i_max_len = 16'd1518; i_stat_id = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < 8; p++) m_in[p] = 1'b0;
    model_clear();
    checks++; if ({o_pkt_cnt, o_bad_cnt, o_runt_cnt, o_over_cnt} !== 128'd0)
      $display("FAIL reset_cnt: got %h want 0", {o_pkt_cnt, o_bad_cnt, o_runt_cnt, o_over_cnt}); else passes++;
    checks++; if (o_byte_cnt !== 48'd0) $display("FAIL reset_byte: got %0d want 0", o_byte_cnt); else passes++;
    checks++; if (o_viol !== 5'd0) $display("FAIL reset_viol: got %b want 0", o_viol); else passes++;
  endtask

  task automatic test_single_runt();
    logic [47:0] mt;
    mt = '0; mt[15:12] = 4'd4;
    drive_beat(3'd2, 12'h00F, 12'h001, 12'h008, 12'h000, mt, 1'b0);
    read_port(2);
    checks++; if (r_pkt !== 32'd1) $display("FAIL runt_pkt: got %0d want 1", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd60) $display("FAIL runt_byte: got %0d want 60", r_byte); else passes++;
    checks++; if (r_runt !== 32'd1) $display("FAIL runt_runt: got %0d want 1", r_runt); else passes++;
    checks++; if (r_viol !== 5'd0) $display("FAIL runt_viol: got %b want 0", r_viol); else passes++;
  endtask

  task automatic send_long(input logic [15:0] maxlen);
    logic [47:0] mt;
    i_max_len = maxlen;
    for (int c = 0; c < 8; c++) begin
      mt = '0;
      if (c == 7) mt[43:40] = 4'd2;
      drive_beat(3'd0, (c < 7) ? 12'hFFF : 12'h7FF, (c == 0) ? 12'h001 : 12'h000,
                 (c == 7) ? 12'h400 : 12'h000, 12'h000, mt, 1'b0);
    end
  endtask

  task automatic test_long_packet();
    send_long(16'd1518);
    read_port(0);
    checks++; if (r_pkt !== 32'd1) $display("FAIL long_pkt: got %0d want 1", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd1518) $display("FAIL long_byte: got %0d want 1518", r_byte); else passes++;
    checks++; if (r_over !== 32'd0) $display("FAIL long_over_at_max: got %0d want 0", r_over); else passes++;
    send_long(16'd1500);
    read_port(0);
    checks++; if (r_over !== 32'd1) $display("FAIL long_over_above_max: got %0d want 1", r_over); else passes++;
    checks++; if (r_byte !== 48'd3036) $display("FAIL long_byte2: got %0d want 3036", r_byte); else passes++;
    i_max_len = 16'd1518;
  endtask

  task automatic test_multi_pkt_cycle();
    drive_beat(3'd1, 12'hFFF, 12'h111, 12'h888, 12'h080, 48'd0, 1'b0);
    read_port(1);
    checks++; if (r_pkt !== 32'd3) $display("FAIL multi_pkt: got %0d want 3", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd192) $display("FAIL multi_byte: got %0d want 192", r_byte); else passes++;
    checks++; if (r_bad !== 32'd1) $display("FAIL multi_bad: got %0d want 1", r_bad); else passes++;
    checks++; if (r_runt !== 32'd0) $display("FAIL multi_runt_64: got %0d want 0", r_runt); else passes++;
  endtask

  task automatic test_interleave();
    drive_beat(3'd3, 12'hFFF, 12'h001, 12'h000, 12'h000, 48'd0, 1'b0);
    drive_beat(3'd4, 12'h00F, 12'h001, 12'h008, 12'h000, 48'd0, 1'b0);
    drive_beat(3'd3, 12'h0FF, 12'h000, 12'h080, 12'h000, 48'd0, 1'b0);
    read_port(3);
    checks++; if (r_pkt !== 32'd1) $display("FAIL ilv_p3_pkt: got %0d want 1", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd320) $display("FAIL ilv_p3_byte: got %0d want 320", r_byte); else passes++;
    read_port(4);
    checks++; if (r_pkt !== 32'd1) $display("FAIL ilv_p4_pkt: got %0d want 1", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd64) $display("FAIL ilv_p4_byte: got %0d want 64", r_byte); else passes++;
    checks++; if (r_viol !== 5'd0) $display("FAIL ilv_viol: got %b want 0", r_viol); else passes++;
  endtask

  task automatic test_violations();
    logic [47:0] mt;
    drive_beat(3'd5, 12'h001, 12'h001, 12'h000, 12'h000, 48'd0, 1'b0);
    drive_beat(3'd5, 12'h001, 12'h001, 12'h000, 12'h000, 48'd0, 1'b0);
    read_port(5);
    checks++; if (r_viol !== 5'b00001) $display("FAIL viol_sop_in_pkt: got %b want 00001", r_viol); else passes++;
    drive_beat(3'd0, 12'h001, 12'h000, 12'h001, 12'h000, 48'd0, 1'b0);
    read_port(0);
    checks++; if (r_viol !== 5'b00111) $display("FAIL viol_lone_eop: got %b want 00111", r_viol); else passes++;
    drive_beat(3'd7, 12'hFFF, 12'h001, 12'h800, 12'h000, 48'd0, 1'b0);
    read_port(0);
    checks++; if (r_viol !== 5'b10111) $display("FAIL viol_bad_id: got %b want 10111", r_viol); else passes++;
    checks++; if (r_pkt !== 32'd2) $display("FAIL viol_bad_id_ignored: got %0d want 2", r_pkt); else passes++;
    mt = '0; mt[3:0] = 4'd3;
    drive_beat(3'd5, 12'h001, 12'h000, 12'h000, 12'h000, mt, 1'b0);
    read_port(5);
    checks++; if (r_viol !== m_viol || r_viol !== 5'b11111)
      $display("FAIL viol_mty_no_eop: got %b want %b", r_viol, m_viol); else passes++;
    do_clear();
    read_port(0);
    checks++; if (r_viol !== 5'd0) $display("FAIL clear_viol: got %b want 0", r_viol); else passes++;
    checks++; if (r_pkt !== 32'd0 || r_byte !== 48'd0 || r_over !== 32'd0)
      $display("FAIL clear_cnt_p0: got pkt %0d byte %0d over %0d want 0", r_pkt, r_byte, r_over); else passes++;
    read_port(1);
    checks++; if (r_pkt !== 32'd0 || r_bad !== 32'd0)
      $display("FAIL clear_cnt_p1: got pkt %0d bad %0d want 0", r_pkt, r_bad); else passes++;
  endtask

  task automatic test_clear_collision();
    drive_beat(3'd4, 12'h001, 12'h001, 12'h000, 12'h000, 48'd0, 1'b0);
    drive_beat(3'd2, 12'h00F, 12'h001, 12'h008, 12'h000, 48'd0, 1'b1);
    read_port(2);
    checks++; if (r_pkt !== 32'd0 || r_byte !== 48'd0)
      $display("FAIL clr_collide_p2: got pkt %0d byte %0d want 0", r_pkt, r_byte); else passes++;
    drive_beat(3'd4, 12'h001, 12'h000, 12'h001, 12'h000, 48'd0, 1'b0);
    read_port(4);
    checks++; if (r_pkt !== 32'd1) $display("FAIL clr_span_pkt: got %0d want 1", r_pkt); else passes++;
    checks++; if (r_byte !== 48'd32) $display("FAIL clr_span_byte: got %0d want 32", r_byte); else passes++;
    checks++; if (r_viol !== 5'd0) $display("FAIL clr_span_viol: got %b want 0", r_viol); else passes++;
  endtask

  task automatic test_random_back_to_back();
    logic [2:0]  id;
    logic [11:0] ena, sop, eop, err;
    logic [47:0] mt;
    i_max_len = 16'($urandom_range(40, 300));
    for (int n = 0; n < 300; n++) begin
      id  = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      ena = 12'($urandom);
      sop = 12'($urandom & $urandom & $urandom);
      eop = 12'($urandom & $urandom);
      err = 12'($urandom);
      mt  = '0;
      for (int s = 0; s < 12; s++)
        if (eop[s] || $urandom_range(0, 15) == 0) mt[s*4 +: 4] = 4'($urandom);
      drive_beat(id, ena, sop, eop, err, mt, 1'b0);
    end
    for (int p = 0; p < 6; p++) begin
      read_port(p);
      checks++; if (r_pkt !== m_pkt[p]) $display("FAIL rnd_pkt[%0d]: got %0d want %0d", p, r_pkt, m_pkt[p]); else passes++;
      checks++; if (r_byte !== m_byte[p][47:0]) $display("FAIL rnd_byte[%0d]: got %0d want %0d", p, r_byte, m_byte[p]); else passes++;
      checks++; if (r_bad !== m_bad[p]) $display("FAIL rnd_bad[%0d]: got %0d want %0d", p, r_bad, m_bad[p]); else passes++;
      checks++; if (r_runt !== m_runt[p]) $display("FAIL rnd_runt[%0d]: got %0d want %0d", p, r_runt, m_runt[p]); else passes++;
      checks++; if (r_over !== m_over[p]) $display("FAIL rnd_over[%0d]: got %0d want %0d", p, r_over, m_over[p]); else passes++;
    end
    checks++; if (r_viol !== m_viol) $display("FAIL rnd_viol: got %b want %b", r_viol, m_viol); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_runt();
    test_long_packet();
    test_multi_pkt_cycle();
    test_interleave();
    test_violations();
    test_clear_collision();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
